uart_rx_core: RTL

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver, 2-flop synchronized input, mid-bit sampling, sticky error flags.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit (8E1) and the parity_err output.
module uart_rx_core #(
  parameter int CLK_FREQ     = 30000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ready_clear,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  input  logic       err_clear
);

  localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  logic        rx_meta_r;
  logic        rx_s;
  state_t      state_r;
  logic [15:0] timer_r;
  logic [2:0]  bit_idx_r;
  logic [7:0]  shift_r;
  logic [7:0]  rx_data_r;
  logic        rx_ready_r;
  logic        rx_busy_r;
  logic        frame_err_r;
  logic        overrun_err_r;
  logic        break_wait_r;
`ifdef UART_RX_PARITY_EN
  logic        parity_err_r;
`endif

  // Two-flop synchronizer for the asynchronous serial line (idle high).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s      <= rx_meta_r;
    end
  end

  // Receive FSM with bit timer, shift register, delivery and sticky flags.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r       <= ST_IDLE;
      timer_r       <= 16'd0;
      bit_idx_r     <= 3'd0;
      shift_r       <= 8'h00;
      rx_data_r     <= 8'h00;
      rx_ready_r    <= 1'b0;
      rx_busy_r     <= 1'b0;
      frame_err_r   <= 1'b0;
      overrun_err_r <= 1'b0;
      break_wait_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r  <= 1'b0;
`endif
    end else begin
      // Clears come first so a same-cycle delivery or new error overrides them.
      if (rx_ready_clear) rx_ready_r <= 1'b0;
      if (err_clear) begin
        frame_err_r   <= 1'b0;
        overrun_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_r  <= 1'b0;
`endif
      end
      if (rx_s) break_wait_r <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (!rx_s && !break_wait_r) begin
            state_r   <= ST_START;
            timer_r   <= HALF_LOAD;
            bit_idx_r <= 3'd0;
            rx_busy_r <= 1'b1;
          end
        end
        ST_START: begin
          if (timer_r == 16'd0) begin
            if (!rx_s) begin
              state_r <= ST_DATA;
              timer_r <= FULL_LOAD;
            end else begin
              state_r   <= ST_IDLE;
              rx_busy_r <= 1'b0;
            end
          end else begin
            timer_r <= timer_r - 16'd1;
          end
        end
        ST_DATA: begin
          if (timer_r == 16'd0) begin
            shift_r <= {rx_s, shift_r[7:1]};
            timer_r <= FULL_LOAD;
            if (bit_idx_r == 3'd7) begin
              bit_idx_r <= 3'd0;
`ifdef UART_RX_PARITY_EN
              state_r   <= ST_PARITY;
`else
              state_r   <= ST_STOP;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            timer_r <= timer_r - 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (timer_r == 16'd0) begin
            if (rx_s != even_parity(shift_r)) parity_err_r <= 1'b1;
            state_r <= ST_STOP;
            timer_r <= FULL_LOAD;
          end else begin
            timer_r <= timer_r - 16'd1;
          end
        end
`endif
        ST_STOP: begin
          if (timer_r == 16'd0) begin
            rx_data_r  <= shift_r;
            rx_ready_r <= 1'b1;
            if (rx_ready_r && !rx_ready_clear) overrun_err_r <= 1'b1;
            if (!rx_s) begin
              frame_err_r  <= 1'b1;
              break_wait_r <= 1'b1;
            end
            state_r   <= ST_IDLE;
            rx_busy_r <= 1'b0;
          end else begin
            timer_r <= timer_r - 16'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          rx_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data     = rx_data_r;
  assign rx_ready    = rx_ready_r;
  assign rx_busy     = rx_busy_r;
  assign frame_err   = frame_err_r;
  assign overrun_err = overrun_err_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_r;
`endif

endmodule
